// File: rtl/ula_ctrl_mdu.sv
// ALU-control decode plus an iterative multiply/divide unit that owns HI/LO.
module ula_ctrl_mdu #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       ALUOp,
    input  logic [5:0]       func,
    input  logic             instr_valid,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic [3:0]       ula_op_out,
    output logic [WIDTH-1:0] mdu_result,
    output logic             mdu_result_sel,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             stall
);

    localparam int unsigned CW = $clog2(WIDTH);

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b1001;
    localparam logic [3:0] ALU_SLTU = 4'b1010;
    localparam logic [3:0] ALU_XOR  = 4'b1011;
    localparam logic [3:0] ALU_NOR  = 4'b1100;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_UND  = 4'b1111;

    localparam logic [5:0] F_MFHI = 6'b010000;
    localparam logic [5:0] F_MTHI = 6'b010001;
    localparam logic [5:0] F_MFLO = 6'b010010;
    localparam logic [5:0] F_MTLO = 6'b010011;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FIX = 2'd2} state_t;

    state_t             state, state_nx;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd, raw_rs;
    logic               is_div, neg_q, neg_r, div_zero;

    logic               r_type, is_mdu, is_start, issue, last_iter;
    logic               rs_neg, rt_neg;
    logic [WIDTH-1:0]   rs_abs, rt_abs;
    logic [WIDTH:0]     mul_sum, div_rem, div_diff;
    logic [2*WIDTH-1:0] mul_nx, div_nx, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix, hi_fix, lo_fix;

    // ALU operation decode from main-control class and R-type function
    always_comb begin
        ula_op_out = ALU_UND;
        case (ALUOp)
            3'b000:         ula_op_out = ALU_ADD;
            3'b001, 3'b011: ula_op_out = ALU_SUB;
            3'b100:         ula_op_out = ALU_OR;
            3'b101:         ula_op_out = ALU_AND;
            3'b110:         ula_op_out = ALU_XOR;
            3'b111:         ula_op_out = ALU_SLT;
            3'b010: begin
                case (func)
                    6'b000000, 6'b000100: ula_op_out = ALU_SLL;
                    6'b000010, 6'b000110: ula_op_out = ALU_SRL;
                    6'b000011, 6'b000111: ula_op_out = ALU_SRA;
                    6'b100000, 6'b100001: ula_op_out = ALU_ADD;
                    6'b100010, 6'b100011: ula_op_out = ALU_SUB;
                    6'b100100:            ula_op_out = ALU_AND;
                    6'b100101:            ula_op_out = ALU_OR;
                    6'b100110:            ula_op_out = ALU_XOR;
                    6'b100111:            ula_op_out = ALU_NOR;
                    6'b101010:            ula_op_out = ALU_SLT;
                    6'b101011:            ula_op_out = ALU_SLTU;
                    default:              ula_op_out = ALU_UND;
                endcase
            end
            default:        ula_op_out = ALU_UND;
        endcase
    end

    // MDU instruction classification and hazard detection
    assign r_type    = instr_valid && (ALUOp == 3'b010);
    assign is_mdu    = r_type && ((func[5:2] == 4'b0100) || (func[5:2] == 4'b0110));
    assign is_start  = r_type && (func[5:2] == 4'b0110);
    assign busy      = (state != S_IDLE);
    assign stall     = is_mdu && busy;
    assign issue     = is_start && !busy;
    assign last_iter = (cnt == CW'(WIDTH - 1));

    // Operand magnitudes; func[0] clear means a signed operation
    assign rs_neg = !func[0] && rs_val[WIDTH-1];
    assign rt_neg = !func[0] && rt_val[WIDTH-1];
    assign rs_abs = rs_neg ? -rs_val : rs_val;
    assign rt_abs = rt_neg ? -rt_val : rt_val;

    // One shift-add multiply step or one restoring-divide step
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        mul_nx   = {mul_sum, acc[WIDTH-1:1]};
        div_rem  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_diff = div_rem - {1'b0, opnd};
        div_nx   = div_diff[WIDTH] ? {div_rem[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                   : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end

    // Sign correction and the HI/LO values committed in FIX
    always_comb begin
        hi_fix   = '0;
        lo_fix   = '0;
        prod_fix = neg_q ? -acc : acc;
        quo_fix  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        if (!is_div) begin
            hi_fix = prod_fix[2*WIDTH-1:WIDTH];
            lo_fix = prod_fix[WIDTH-1:0];
        end else if (div_zero) begin
            hi_fix = raw_rs;
            lo_fix = '1;
        end else begin
            hi_fix = rem_fix;
            lo_fix = quo_fix;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    // Next-state logic: IDLE -> RUN (WIDTH cycles) -> FIX -> IDLE
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (issue) state_nx = S_RUN;
            S_RUN:   if (last_iter) state_nx = S_FIX;
            S_FIX:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Operand capture, iteration, and HI/LO updates
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            acc      <= '0;
            opnd     <= '0;
            raw_rs   <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (issue) begin
                        cnt      <= '0;
                        is_div   <= func[1];
                        neg_q    <= rs_neg ^ rt_neg;
                        neg_r    <= rs_neg;
                        div_zero <= (rt_val == '0);
                        raw_rs   <= rs_val;
                        opnd     <= func[1] ? rt_abs : rs_abs;
                        acc      <= {{WIDTH{1'b0}}, (func[1] ? rs_abs : rt_abs)};
                    end else if (r_type && (func == F_MTHI)) begin
                        hi <= rs_val;
                    end else if (r_type && (func == F_MTLO)) begin
                        lo <= rs_val;
                    end
                end
                S_RUN: begin
                    cnt <= cnt + CW'(1);
                    acc <= is_div ? div_nx : mul_nx;
                end
                S_FIX: begin
                    cnt <= '0;
                    hi  <= hi_fix;
                    lo  <= lo_fix;
                end
                default: ;
            endcase
        end
    end

    // mfhi/mflo read port, only while the unit is idle
    always_comb begin
        mdu_result     = '0;
        mdu_result_sel = 1'b0;
        if (r_type && !busy) begin
            if (func == F_MFHI) begin
                mdu_result     = hi;
                mdu_result_sel = 1'b1;
            end else if (func == F_MFLO) begin
                mdu_result     = lo;
                mdu_result_sel = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ula_ctrl_mdu.sv
// Self-checking bench for ula_ctrl_mdu: decode, MDU arithmetic, hazards, reset.
module tb_ula_ctrl_mdu;

    localparam int unsigned W  = 32;
    localparam int unsigned W8 = 8;

    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    logic          clk;
    logic          rst_n;
    logic [2:0]    alu_op;
    logic [5:0]    func;
    logic          instr_valid;
    logic [W-1:0]  rs_val, rt_val;
    logic [3:0]    ula_op_out;
    logic [W-1:0]  mdu_result;
    logic          mdu_result_sel;
    logic [W-1:0]  hi, lo;
    logic          busy, stall;

    logic [2:0]    alu_op8;
    logic [5:0]    func8;
    logic          valid8;
    logic [W8-1:0] rs8, rt8;
    logic [3:0]    op_out8;
    logic [W8-1:0] res8;
    logic          sel8;
    logic [W8-1:0] hi8, lo8;
    logic          busy8, stall8;

    int n_checks;
    int n_pass;

    ula_ctrl_mdu #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .ALUOp(alu_op), .func(func),
        .instr_valid(instr_valid), .rs_val(rs_val), .rt_val(rt_val),
        .ula_op_out(ula_op_out), .mdu_result(mdu_result),
        .mdu_result_sel(mdu_result_sel), .hi(hi), .lo(lo),
        .busy(busy), .stall(stall)
    );

    ula_ctrl_mdu #(.WIDTH(W8)) dut8 (
        .clk(clk), .rst_n(rst_n), .ALUOp(alu_op8), .func(func8),
        .instr_valid(valid8), .rs_val(rs8), .rt_val(rt8),
        .ula_op_out(op_out8), .mdu_result(res8),
        .mdu_result_sel(sel8), .hi(hi8), .lo(lo8),
        .busy(busy8), .stall(stall8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference ALU decode written as the opcode table
    function automatic logic [3:0] ref_alu(input logic [2:0] op, input logic [5:0] f);
        case (op)
            3'b000:         return 4'b0010;
            3'b001, 3'b011: return 4'b0110;
            3'b100:         return 4'b0001;
            3'b101:         return 4'b0000;
            3'b110:         return 4'b1011;
            3'b111:         return 4'b0111;
            default:        ;
        endcase
        case (f)
            6'b000000, 6'b000100: return 4'b1001;
            6'b000010, 6'b000110: return 4'b1000;
            6'b000011, 6'b000111: return 4'b1101;
            6'b100000, 6'b100001: return 4'b0010;
            6'b100010, 6'b100011: return 4'b0110;
            6'b100100:            return 4'b0000;
            6'b100101:            return 4'b0001;
            6'b100110:            return 4'b1011;
            6'b100111:            return 4'b1100;
            6'b101010:            return 4'b0111;
            6'b101011:            return 4'b1010;
            default:              return 4'b1111;
        endcase
    endfunction

    // Reference MDU result using plain 64-bit integer arithmetic
    function automatic void ref_mdu(input int w, input logic [5:0] f,
                                    input longint unsigned a, input longint unsigned b,
                                    output longint unsigned h, output longint unsigned l);
        longint unsigned mask;
        longint sa, sb, p, q, r;
        bit sgn;
        mask = (64'd1 << w) - 64'd1;
        sgn  = !f[0];
        sa   = longint'(a);
        sb   = longint'(b);
        if (sgn && a[w-1]) sa = sa - (longint'(1) << w);
        if (sgn && b[w-1]) sb = sb - (longint'(1) << w);
        if (!f[1]) begin
            p = sa * sb;
            h = ($unsigned(p) >> w) & mask;
            l = $unsigned(p) & mask;
        end else if (b == 0) begin
            h = a;
            l = mask;
        end else if (sgn && sa == -(longint'(1) << (w - 1)) && sb == -1) begin
            h = 0;
            l = 64'd1 << (w - 1);
        end else begin
            q = sa / sb;
            r = sa % sb;
            h = $unsigned(r) & mask;
            l = $unsigned(q) & mask;
        end
    endfunction

    task automatic drive(input logic [2:0] op, input logic [5:0] f, input logic v,
                         input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        alu_op = op; func = f; instr_valid = v; rs_val = a; rt_val = b;
        #1;
    endtask

    // Issue one MDU op; while busy present either mflo (hazard) or random non-MDU work
    task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          input bit hazard);
        longint unsigned eh, el;
        int nbusy, nstall;
        logic [2:0] op;
        logic [5:0] ff;
        ref_mdu(32, f, 64'(a), 64'(b), eh, el);
        drive(3'b010, f, 1'b1, a, b);
        check("issue_stall", 64'(stall), 64'd0);
        nbusy = 0;
        nstall = 0;
        for (int k = 0; k < 200; k++) begin
            if (hazard) begin
                drive(3'b010, F_MFLO, 1'b1, $urandom, $urandom);
            end else begin
                op = 3'($urandom_range(0, 7));
                ff = (op == 3'b010) ? 6'b100000 : 6'($urandom);
                drive(op, ff, 1'b1, $urandom, $urandom);
                check("alu_during_run", 64'(ula_op_out), 64'(ref_alu(op, ff)));
            end
            if (!busy) break;
            nbusy++;
            if (stall) nstall++;
        end
        check("busy_cycles", 64'(nbusy), 64'(W + 1));
        check("stall_cycles", 64'(nstall), hazard ? 64'(W + 1) : 64'd0);
        check("hi", 64'(hi), eh);
        check("lo", 64'(lo), el);
        if (hazard) begin
            check("mflo_after_stall", 64'(mdu_result), el);
            check("mflo_sel", 64'(mdu_result_sel), 64'd1);
        end else begin
            drive(3'b010, F_MFHI, 1'b1, 32'd0, 32'd0);
            check("mfhi_read", 64'(mdu_result), eh);
            check("mfhi_sel", 64'(mdu_result_sel), 64'd1);
        end
        drive(3'b000, 6'd0, 1'b0, 32'd0, 32'd0);
        check("idle_sel", 64'(mdu_result_sel), 64'd0);
        check("idle_result", 64'(mdu_result), 64'd0);
    endtask

    task automatic op8(input logic [5:0] f, input logic [7:0] a, input logic [7:0] b);
        longint unsigned eh, el;
        int nbusy;
        ref_mdu(8, f, 64'(a), 64'(b), eh, el);
        @(negedge clk);
        alu_op8 = 3'b010; func8 = f; valid8 = 1'b1; rs8 = a; rt8 = b;
        nbusy = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            valid8 = 1'b0;
            #1;
            if (!busy8) break;
            nbusy++;
        end
        check("w8_busy_cycles", 64'(nbusy), 64'(W8 + 1));
        check("w8_hi", 64'(hi8), eh);
        check("w8_lo", 64'(lo8), el);
    endtask

    task automatic decode_chk(input string tag, input logic [2:0] op, input logic [5:0] f,
                              input logic [3:0] exp);
        drive(op, f, 1'b0, 32'd0, 32'd0);
        check(tag, 64'(ula_op_out), 64'(exp));
    endtask

    initial begin
        longint unsigned eh, el;
        logic [31:0] x;
        int nstall;

        n_checks = 0;
        n_pass   = 0;
        rst_n = 1'b1;
        alu_op = '0; func = '0; instr_valid = 1'b0; rs_val = '0; rt_val = '0;
        alu_op8 = '0; func8 = '0; valid8 = 1'b0; rs8 = '0; rt8 = '0;
        #1 rst_n = 1'b0;
        #1;
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_stall", 64'(stall), 64'd0);
        check("rst_sel", 64'(mdu_result_sel), 64'd0);
        check("rst_result", 64'(mdu_result), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        decode_chk("dec_srl", 3'b010, 6'b000010, 4'b1000);
        decode_chk("dec_sltu", 3'b010, 6'b101011, 4'b1010);
        decode_chk("dec_jr", 3'b010, 6'b001000, 4'b1111);
        decode_chk("dec_andi", 3'b101, 6'b000000, 4'b0000);
        decode_chk("dec_xori", 3'b110, 6'b111111, 4'b1011);
        decode_chk("dec_mult_func", 3'b010, F_MULT, 4'b1111);
        for (int i = 0; i < 64; i++) begin
            logic [2:0] op;
            logic [5:0] f;
            op = 3'($urandom_range(0, 7));
            f  = 6'($urandom);
            decode_chk("dec_rand", op, f, ref_alu(op, f));
        end

        run_op(F_MULT, 32'hFFFF_FFFD, 32'd5, 1'b0);
        check("mult_hi_const", 64'(hi), 64'hFFFF_FFFF);
        check("mult_lo_const", 64'(lo), 64'hFFFF_FFF1);
        run_op(F_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b1);
        check("multu_hi_const", 64'(hi), 64'd1);
        check("multu_lo_const", 64'(lo), 64'hFFFF_FFFE);
        run_op(F_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
        check("div_lo_const", 64'(lo), 64'hFFFF_FFFD);
        check("div_hi_const", 64'(hi), 64'hFFFF_FFFF);
        run_op(F_DIVU, 32'd7, 32'd0, 1'b1);
        check("divz_hi_const", 64'(hi), 64'd7);
        check("divz_lo_const", 64'(lo), 64'hFFFF_FFFF);
        run_op(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        check("ovf_lo_const", 64'(lo), 64'h8000_0000);
        check("ovf_hi_const", 64'(hi), 64'd0);
        run_op(F_DIV, 32'hFFFF_FFF9, 32'd0, 1'b0);

        for (int i = 0; i < 20; i++) begin
            logic [5:0] f;
            logic [31:0] a, b;
            f = {4'b0110, 2'($urandom_range(0, 3))};
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 2)) : $urandom;
            if (($urandom_range(0, 3) == 0)) a = 32'($urandom_range(0, 1000));
            run_op(f, a, b, 1'($urandom_range(0, 1)));
        end

        // mthi presented while busy must wait and leave the FIX write intact
        ref_mdu(32, F_MULTU, 64'h1234_5678, 64'h9ABC_DEF0, eh, el);
        x = $urandom;
        drive(3'b010, F_MULTU, 1'b1, 32'h1234_5678, 32'h9ABC_DEF0);
        nstall = 0;
        for (int k = 0; k < 200; k++) begin
            drive(3'b010, F_MTHI, 1'b1, x, 32'd0);
            if (!busy) break;
            if (stall) nstall++;
        end
        check("mthi_stall_cycles", 64'(nstall), 64'(W + 1));
        check("mthi_fix_hi", 64'(hi), eh);
        check("mthi_fix_lo", 64'(lo), el);
        drive(3'b010, F_MFHI, 1'b1, 32'd0, 32'd0);
        check("mthi_accepted", 64'(mdu_result), 64'(x));
        check("mthi_keeps_lo", 64'(lo), el);

        // mthi/mtlo followed by mfhi/mflo
        for (int i = 0; i < 4; i++) begin
            logic [31:0] vh, vl;
            vh = $urandom;
            vl = $urandom;
            drive(3'b010, F_MTHI, 1'b1, vh, 32'd0);
            drive(3'b010, F_MTLO, 1'b1, vl, 32'd0);
            drive(3'b010, F_MFHI, 1'b1, 32'd0, 32'd0);
            check("mfhi_after_mthi", 64'(mdu_result), 64'(vh));
            drive(3'b010, F_MFLO, 1'b1, 32'd0, 32'd0);
            check("mflo_after_mtlo", 64'(mdu_result), 64'(vl));
        end

        // Reset during RUN at iteration 10
        drive(3'b010, F_MTHI, 1'b1, 32'hA5A5_0001, 32'd0);
        drive(3'b010, F_MULT, 1'b1, $urandom, $urandom);
        for (int k = 0; k < 11; k++) drive(3'b000, 6'd0, 1'b0, 32'd0, 32'd0);
        check("pre_rst_busy", 64'(busy), 64'd1);
        check("pre_rst_hi", 64'(hi), 64'hA5A5_0001);
        rst_n = 1'b0;
        #1;
        check("midrun_rst_busy", 64'(busy), 64'd0);
        check("midrun_rst_hi", 64'(hi), 64'd0);
        check("midrun_rst_lo", 64'(lo), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(3'b010, F_MTLO, 1'b1, 32'h0000_1234, 32'd0);
        drive(3'b010, F_MFLO, 1'b1, 32'd0, 32'd0);
        check("post_rst_mflo", 64'(mdu_result), 64'h1234);
        check("post_rst_sel", 64'(mdu_result_sel), 64'd1);
        drive(3'b000, 6'd0, 1'b0, 32'd0, 32'd0);

        // WIDTH=8 instance
        op8(F_MULT, 8'hFD, 8'h05);
        check("w8_hi_const", 64'(hi8), 64'hFF);
        check("w8_lo_const", 64'(lo8), 64'hF1);
        op8(F_DIV, 8'h80, 8'hFF);
        for (int i = 0; i < 8; i++) begin
            op8({4'b0110, 2'($urandom_range(0, 3))}, 8'($urandom),
                ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
